// File: rtl/minirisc_sequencer.sv
// minirisc_sequencer
// Fetches bytes from a 16x8 program buffer and feeds them, one command or
// operand per cycle, to an accumulator core's ui_in, pacing itself on the
// core's state nibble.
// Build option: define MINIRISC_SEQ_LOOP_EN to let pc wrap from 15 to 0 and
// keep executing. Without it, running off the end of the buffer finishes the
// program, and a LOAD sitting at address 15 is rejected.
`timescale 1ns/1ps

module minirisc_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [7:0] prog_data,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] core_state,
   output logic [7:0] cmd_out,
   output logic [3:0] pc,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Opcode map of the accumulator core
   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_LOAD  = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_STORE = 8'h04;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   // The fourth consecutive busy WAIT cycle trips the watchdog
   localparam logic [2:0] WDOG_LAST = 3'd3;

`ifdef MINIRISC_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_OPERAND,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   // Architectural state
   state_t     state_q;
   logic [7:0] cmd_q;
   logic [3:0] pc_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;
   logic       stop_q;
   logic       wait_first_q;
   logic [2:0] wdog_q;
   logic [7:0] buf_q [16];

   // Decode of the word under pc
   logic [7:0] cur_word;
   logic [3:0] pc_plus1;
   logic       op_nop;
   logic       op_halt;
   logic       op_load;
   logic       op_issue;
   logic       op_illegal;
   logic       load_at_end;

   // Where execution goes once the current instruction retires
   state_t     retire_state_d;
   logic [3:0] retire_pc_d;
   logic       retire_busy_d;

   assign cmd_out = cmd_q;
   assign pc      = pc_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

   // Decode the current buffer word; the buffer is frozen while busy so this
   // stays stable across FETCH, ISSUE and OPERAND of one instruction
   always_comb begin
      cur_word    = buf_q[pc_q];
      pc_plus1    = pc_q + 4'd1;
      op_nop      = (cur_word == OP_NOP);
      op_halt     = (cur_word == OP_HALT);
      op_load     = (cur_word == OP_LOAD);
      op_issue    = (cur_word == OP_LOAD) || (cur_word == OP_ADD) ||
                    (cur_word == OP_SUB)  || (cur_word == OP_STORE);
      op_illegal  = !(op_nop || op_halt || op_issue);
      // Without wrap-around the operand of a LOAD at 15 does not exist
      load_at_end = !LOOP_EN && op_load && (pc_q == 4'hF);
   end

   // Retirement target: a pending stop wins, then the end-of-buffer rule
   always_comb begin
      retire_state_d = S_FETCH;
      retire_pc_d    = pc_plus1;
      if (stop_q || stop) begin
         retire_state_d = S_IDLE;
         retire_pc_d    = pc_q;
      end else if (!LOOP_EN && (pc_q == 4'hF)) begin
         retire_state_d = S_DONE;
         retire_pc_d    = pc_q;
      end
      retire_busy_d = (retire_state_d == S_FETCH);
   end

   // Program buffer: host writes land only while no program is executing,
   // so a write issued together with start is visible to the first fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= 8'h00;
         end
      end else if (prog_we && !busy_q) begin
         buf_q[prog_addr] <= prog_data;
      end
   end

   // Sequencer FSM with registered outputs; cmd_out defaults to 0x00 and is
   // loaded only on the transitions into ISSUE and OPERAND
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cmd_q        <= 8'h00;
         pc_q         <= 4'h0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         stop_q       <= 1'b0;
         wait_first_q <= 1'b0;
         wdog_q       <= 3'd0;
      end else if (!ena) begin
         state_q      <= S_IDLE;
         cmd_q        <= 8'h00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         stop_q       <= 1'b0;
         wait_first_q <= 1'b0;
         wdog_q       <= 3'd0;
      end else begin
         cmd_q <= 8'h00;
         // Abort requests are remembered until the next instruction boundary
         if (busy_q && stop) begin
            stop_q <= 1'b1;
         end
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_q <= S_FETCH;
                  pc_q    <= 4'h0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  stop_q  <= 1'b0;
               end
            end

            S_FETCH: begin
               if (op_halt) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  stop_q  <= 1'b0;
               end else if (op_illegal || load_at_end) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  stop_q  <= 1'b0;
               end else if (op_nop) begin
                  // NOP never reaches the core; it retires straight from FETCH
                  state_q <= retire_state_d;
                  pc_q    <= retire_pc_d;
                  busy_q  <= retire_busy_d;
                  done_q  <= (retire_state_d == S_DONE);
                  if (!retire_busy_d) begin
                     stop_q <= 1'b0;
                  end
               end else if (core_state == 4'h0) begin
                  // Core-bound opcode: only hand it over once the core is idle
                  state_q <= S_ISSUE;
                  cmd_q   <= cur_word;
               end
            end

            S_ISSUE: begin
               if (op_load) begin
                  // The operand word follows the opcode, wrapping when enabled
                  state_q <= S_OPERAND;
                  pc_q    <= pc_plus1;
                  cmd_q   <= buf_q[pc_plus1];
               end else begin
                  state_q      <= S_WAIT;
                  wait_first_q <= 1'b1;
                  wdog_q       <= 3'd0;
               end
            end

            S_OPERAND: begin
               state_q      <= S_WAIT;
               wait_first_q <= 1'b1;
               wdog_q       <= 3'd0;
            end

            S_WAIT: begin
               // The first WAIT cycle gives the core a cycle to react before
               // an idle nibble is trusted as completion
               wait_first_q <= 1'b0;
               if (core_state != 4'h0) begin
                  if (wdog_q == WDOG_LAST) begin
                     state_q <= S_ERR;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                     stop_q  <= 1'b0;
                     wdog_q  <= 3'd0;
                  end else begin
                     wdog_q <= wdog_q + 3'd1;
                  end
               end else if (wait_first_q) begin
                  wdog_q <= 3'd0;
               end else begin
                  wdog_q  <= 3'd0;
                  state_q <= retire_state_d;
                  pc_q    <= retire_pc_d;
                  busy_q  <= retire_busy_d;
                  done_q  <= (retire_state_d == S_DONE);
                  if (!retire_busy_d) begin
                     stop_q <= 1'b0;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               stop_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minirisc_sequencer.sv
// Testbench for minirisc_sequencer: directed scenarios plus random programs
// checked cycle by cycle against a program-level interpreter.
`timescale 1ns/1ps

module tb_minirisc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       start;
   logic       stop;
   logic [3:0] core_state;
   logic [7:0] cmd_out;
   logic [3:0] pc;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MINIRISC_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   // Reference program image and expected per-cycle (cmd_out, pc) while busy
   logic [7:0] prog_m [16];
   logic [7:0] exp_cmd_q [$];
   logic [3:0] exp_pc_q [$];
   logic       exp_done;
   logic       exp_err;
   logic [3:0] exp_pc;
   logic       exp_pc_valid;

   always #5 clk = ~clk;

   minirisc_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .start      (start),
      .stop       (stop),
      .core_state (core_state),
      .cmd_out    (cmd_out),
      .pc         (pc),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   task automatic clear_exp();
      exp_cmd_q.delete();
      exp_pc_q.delete();
      exp_done     = 1'b0;
      exp_err      = 1'b0;
      exp_pc       = 4'h0;
      exp_pc_valid = 1'b1;
   endtask

   task automatic push(input logic [7:0] c, input logic [3:0] p);
      exp_cmd_q.push_back(c);
      exp_pc_q.push_back(p);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog_m[i] = 8'h00;
   endtask

   // Program interpreter with an always-idle core: every instruction opens
   // with a quiet fetch cycle; core-bound ones then issue the opcode (and
   // operand for LOAD) and spend two wait cycles.
   task automatic model_run(output bit ok);
      int p;
      logic [7:0] op;
      p  = 0;
      ok = 1'b0;
      clear_exp();
      for (int step = 0; step < 48; step++) begin
         op = prog_m[p];
         push(8'h00, 4'(p));
         if (op == 8'hFF) begin
            exp_done = 1'b1; exp_pc = 4'(p); ok = 1'b1; return;
         end
         if (!(op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04})) begin
            exp_err = 1'b1; exp_pc = 4'(p); ok = 1'b1; return;
         end
         if (op == 8'h01 && p == 15 && !LOOP_EN) begin
            exp_err = 1'b1; exp_pc = 4'(p); ok = 1'b1; return;
         end
         if (op != 8'h00) begin
            push(op, 4'(p));
            if (op == 8'h01) begin
               p = (p + 1) % 16;
               push(prog_m[p], 4'(p));
            end
            push(8'h00, 4'(p));
            push(8'h00, 4'(p));
         end
         if (p == 15 && !LOOP_EN) begin
            exp_done = 1'b1; exp_pc = 4'hF; ok = 1'b1; return;
         end
         p = (p + 1) % 16;
      end
   endtask

   task automatic gen_prog();
      int r;
      for (int i = 0; i < 16; i++) begin
         r = $urandom_range(0, 15);
         if (r <= 3)       prog_m[i] = 8'h00;
         else if (r <= 5)  prog_m[i] = 8'h01;
         else if (r <= 7)  prog_m[i] = 8'h02;
         else if (r == 8)  prog_m[i] = 8'h03;
         else if (r == 9)  prog_m[i] = 8'h04;
         else if (r == 10) prog_m[i] = 8'hFF;
         else if (r == 11) prog_m[i] = 8'($urandom_range(5, 254));
         else              prog_m[i] = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 3) == 0) prog_m[15] = 8'h01;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = prog_m[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walk the expected busy trace one cycle at a time, optionally pulsing
   // stop or moving core_state at given trace indices, then check the outcome.
   task automatic follow(input string tag, input int stop_at, input int core_set_at, input int core_clr_at);
      int bad0;
      logic [3:0] pc_seen;
      bad0 = n_bad;
      for (int i = 0; i < exp_cmd_q.size(); i++) begin
         check({tag, "_cyc"}, {busy, pc, cmd_out}, {1'b1, exp_pc_q[i], exp_cmd_q[i]});
         if (n_bad != bad0) break;
         stop = (i == stop_at);
         if (i == core_set_at) core_state = 4'h2;
         if (i == core_clr_at) core_state = 4'h0;
         @(negedge clk);
      end
      stop = 1'b0;
      if (n_bad != bad0) begin
         for (int k = 0; k < 200 && busy; k++) @(negedge clk);
      end
      pc_seen = exp_pc_valid ? pc : 4'h0;
      check({tag, "_end"}, {busy, done, err, pc_seen, cmd_out},
            {1'b0, exp_done, exp_err, (exp_pc_valid ? exp_pc : 4'h0), 8'h00});
      $display("run %-8s cycles=%0d done=%0b err=%0b pc=%0d", tag, exp_cmd_q.size(), done, err, pc);
      if (busy) begin
         ena = 1'b0;
         @(negedge clk);
         ena = 1'b1;
      end
   endtask

   // All-NOP sweep: finishes after 16 fetches, or keeps cycling pc when wrapping
   task automatic nop_sweep(input string tag);
      bit ok;
      clear_prog();
      if (LOOP_EN) begin
         clear_exp();
         for (int i = 0; i < 40; i++) push(8'h00, 4'(i % 16));
         exp_pc_valid = 1'b0;
         kick();
         follow(tag, 39, -1, -1);
      end else begin
         model_run(ok);
         kick();
         follow(tag, -1, -1, -1);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      rst_n = 1'b0; ena = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
      start = 1'b0; stop = 1'b0; core_state = 4'h0;
      repeat (2) @(negedge clk);
      check("reset_outs", {busy, done, err, pc, cmd_out}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // LOAD 5A / ADD / HALT
      clear_prog();
      prog_m[0] = 8'h01; prog_m[1] = 8'h5A; prog_m[2] = 8'h02; prog_m[3] = 8'hFF;
      load_prog();
      clear_exp();
      push(8'h00, 4'd0); push(8'h01, 4'd0); push(8'h5A, 4'd1); push(8'h00, 4'd1); push(8'h00, 4'd1);
      push(8'h00, 4'd2); push(8'h02, 4'd2); push(8'h00, 4'd2); push(8'h00, 4'd2);
      push(8'h00, 4'd3);
      exp_done = 1'b1; exp_pc = 4'd3;
      kick();
      follow("load_add", -1, -1, -1);

      // Illegal first word
      clear_prog();
      prog_m[0] = 8'h07;
      load_prog();
      clear_exp();
      push(8'h00, 4'd0);
      exp_err = 1'b1;
      kick();
      follow("illegal", -1, -1, -1);
      for (int i = 0; i < 3; i++) begin
         check("illegal_quiet", {err, cmd_out}, {1'b1, 8'h00});
         @(negedge clk);
      end

      // Watchdog: core stuck busy after ADD
      clear_prog();
      prog_m[0] = 8'h02; prog_m[1] = 8'hFF;
      load_prog();
      clear_exp();
      push(8'h00, 4'd0); push(8'h02, 4'd0);
      for (int i = 0; i < 4; i++) push(8'h00, 4'd0);
      exp_err = 1'b1;
      kick();
      follow("watchdog", -1, 1, -1);
      core_state = 4'h0;

      // Stop during LOAD operand: operand still goes out, then IDLE
      clear_prog();
      prog_m[0] = 8'h01; prog_m[1] = 8'h33; prog_m[2] = 8'h03; prog_m[3] = 8'h03; prog_m[4] = 8'hFF;
      load_prog();
      clear_exp();
      push(8'h00, 4'd0); push(8'h01, 4'd0); push(8'h33, 4'd1); push(8'h00, 4'd1); push(8'h00, 4'd1);
      exp_pc_valid = 1'b0;
      kick();
      follow("stop_ld", 2, -1, -1);

      // FETCH stalls while the core is busy
      clear_prog();
      prog_m[0] = 8'h03; prog_m[1] = 8'hFF;
      load_prog();
      clear_exp();
      push(8'h00, 4'd0); push(8'h00, 4'd0); push(8'h00, 4'd0); push(8'h03, 4'd0);
      push(8'h00, 4'd0); push(8'h00, 4'd0); push(8'h00, 4'd1);
      exp_done = 1'b1; exp_pc = 4'd1;
      core_state = 4'h1;
      kick();
      follow("stall", -1, -1, 2);

      // Write while busy is dropped; ena low aborts but keeps the buffer
      clear_prog();
      prog_m[0] = 8'h02; prog_m[1] = 8'hFF;
      load_prog();
      kick();
      check("ena_fetch", {busy, cmd_out}, {1'b1, 8'h00});
      prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h07;
      @(negedge clk);
      check("ena_issue", {busy, cmd_out}, {1'b1, 8'h02});
      prog_we = 1'b0; ena = 1'b0;
      @(negedge clk);
      check("ena_low", {busy, done, err, cmd_out}, 32'h0);
      ena = 1'b1;
      model_run(ok);
      kick();
      follow("ena_rerun", -1, -1, -1);

      // start together with a write: the first fetch sees the new word
      prog_m[0] = 8'h04;
      model_run(ok);
      @(negedge clk);
      start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h04;
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      follow("start_wr", -1, -1, -1);

      // All-NOP buffer
      clear_prog();
      load_prog();
      nop_sweep("nops");

      // Asynchronous reset in the middle of an ISSUE cycle
      clear_prog();
      prog_m[0] = 8'h02; prog_m[1] = 8'hFF;
      load_prog();
      kick();
      @(negedge clk);
      check("rst_issue", cmd_out, 8'h02);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {busy, pc, cmd_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nop_sweep("rst_clr");

      // Random programs
      for (int n = 0; n < 30; n++) begin
         ok = 1'b0;
         for (int a = 0; a < 50 && !ok; a++) begin
            gen_prog();
            model_run(ok);
         end
         if (!ok) begin
            prog_m[0] = 8'hFF;
            model_run(ok);
         end
         load_prog();
         kick();
         follow("rand", -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
